avg_frame_sequencer: RTL and testbench

//  Control FSM for the growing-sum bin averager.
//  - On a start command, arms and counts FFT frames.
//  - Per frame: drives per-bin accumulate strobes and the bin index to the per-bin accumulator datapath.
//  - After 2^N_AVGS frames: requests a dump of the sums over a valid/ready handshake, then returns idle.
//  - Sits between the FFT frame strobe and the bin accumulator/collection datapath.

---
 rtl/avg_frame_sequencer_pkg.sv | 17 +
 rtl/avg_frame_sequencer_if.sv | 36 +++
 rtl/avg_frame_sequencer_bin_counter.sv | 33 +++
 rtl/avg_frame_sequencer.sv | 127 ++++++++++++
 tb/tb_avg_frame_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avg_frame_sequencer_pkg.sv
// Shared types and helpers for the growing-sum bin averager frame sequencer.
package avg_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    FRAME = 3'd2,
    GAP   = 3'd3,
    DUMP  = 3'd4
  } state_t;

  // Number of frames summed in one averaging run.
  function automatic int avg_frames(input int n_avgs);
    return 1 << n_avgs;
  endfunction

endpackage

// File: rtl/avg_frame_sequencer_if.sv
// Command/status bundle between the frame sequencer and its surroundings
// (FFT strobe source, bin accumulator datapath and dump consumer).
interface avg_frame_sequencer_if #(
  parameter int BINS   = 4,
  parameter int N_AVGS = 7
) ();

  localparam int BIN_W = $clog2(BINS);

  logic              start;
  logic              abort;
  logic              fft_valid;
  logic              dump_ready;

  logic              acc_en;
  logic              acc_clear;
  logic [BIN_W-1:0]  acc_bin;
  logic              dump_valid;
  logic              busy;
  logic              done;
  logic              overrun;
  logic [N_AVGS:0]   frame_cnt;

  // Controller side: issues commands, frame strobes and dump acceptance.
  modport master (
    output start, abort, fft_valid, dump_ready,
    input  acc_en, acc_clear, acc_bin, dump_valid, busy, done, overrun, frame_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, abort, fft_valid, dump_ready,
    output acc_en, acc_clear, acc_bin, dump_valid, busy, done, overrun, frame_cnt
  );

endinterface

// File: rtl/avg_frame_sequencer_bin_counter.sv
// Modulo-BINS bin index counter with synchronous load-zero, step enable
// and a flag marking the last bin of a frame.
module avg_frame_sequencer_bin_counter #(
  parameter int BINS = 4
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic                     clear_i,
  input  logic                     step_i,
  output logic [$clog2(BINS)-1:0]  count_o,
  output logic                     last_o
);

  localparam int BIN_W = $clog2(BINS);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BINS - 1);

  logic [BIN_W-1:0] count_q;

  // Wrapping at the last bin lets back-to-back frames restart at bin 0 for free.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (step_i) begin
      count_q <= (count_q == LAST_BIN) ? '0 : count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_BIN);

endmodule

// File: rtl/avg_frame_sequencer.sv
// Control FSM for the growing-sum bin averager: counts 2^N_AVGS FFT frames,
// strobes per-bin accumulation, then hands the sums off over valid/ready.
module avg_frame_sequencer
  import avg_frame_sequencer_pkg::*;
#(
  parameter int BINS   = 4,
  parameter int N_AVGS = 7
) (
  input  logic                  clk,
  input  logic                  areset_n,
  avg_frame_sequencer_if.slave  bus
);

  localparam int BIN_W = $clog2(BINS);
  localparam int CNT_W = N_AVGS + 1;
  localparam logic [CNT_W-1:0] FRAMES = CNT_W'(avg_frames(N_AVGS));

  state_t            state_q;
  logic              acc_en_q;
  logic              acc_clear_q;
  logic              dump_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              overrun_q;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic              bin_clear;
  logic              bin_step;
  logic              bin_last;
  logic [BIN_W-1:0]  bin_idx;
  logic [CNT_W-1:0]  frame_cnt_inc;

  // Bin index restarts on a fresh frame strobe and advances every FRAME cycle.
  assign bin_clear = bus.abort
                   | (((state_q == ARMED) || (state_q == GAP)) && bus.fft_valid);
  assign bin_step  = (state_q == FRAME);
  assign frame_cnt_inc = frame_cnt_q + 1'b1;

  avg_frame_sequencer_bin_counter #(
    .BINS (BINS)
  ) u_bin_counter (
    .clk      (clk),
    .areset_n (areset_n),
    .clear_i  (bin_clear),
    .step_i   (bin_step),
    .count_o  (bin_idx),
    .last_o   (bin_last)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= IDLE;
      acc_en_q     <= 1'b0;
      acc_clear_q  <= 1'b0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q      <= IDLE;
        acc_en_q     <= 1'b0;
        acc_clear_q  <= 1'b0;
        dump_valid_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q     <= ARMED;
              busy_q      <= 1'b1;
              frame_cnt_q <= '0;
              overrun_q   <= 1'b0;
            end
          end
          ARMED, GAP: begin
            if (bus.fft_valid) begin
              state_q     <= FRAME;
              acc_en_q    <= 1'b1;
              acc_clear_q <= (frame_cnt_q == '0);
            end
          end
          FRAME: begin
            // Only the last-bin cycle may chain a new frame; earlier strobes are overruns.
            if (bin_last) begin
              frame_cnt_q <= frame_cnt_inc;
              acc_clear_q <= 1'b0;
              if (frame_cnt_inc == FRAMES) begin
                state_q      <= DUMP;
                acc_en_q     <= 1'b0;
                dump_valid_q <= 1'b1;
              end else if (!bus.fft_valid) begin
                state_q  <= GAP;
                acc_en_q <= 1'b0;
              end
            end else if (bus.fft_valid) begin
              overrun_q <= 1'b1;
            end
          end
          DUMP: begin
            if (dump_valid_q && bus.dump_ready) begin
              state_q      <= IDLE;
              dump_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.acc_en     = acc_en_q;
  assign bus.acc_clear  = acc_clear_q;
  assign bus.acc_bin    = bin_idx;
  assign bus.dump_valid = dump_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_avg_frame_sequencer.sv
// Directed self-checking bench for avg_frame_sequencer with BINS=4, N_AVGS=2.
module tb_avg_frame_sequencer;

  logic clk;
  logic areset_n;
  int   checks;
  int   failures;

  avg_frame_sequencer_if #(.BINS(4), .N_AVGS(2)) bus ();

  avg_frame_sequencer #(
    .BINS   (4),
    .N_AVGS (2)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    areset_n       = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.fft_valid  = 1'b0;
    bus.dump_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.acc_en, bus.acc_clear, bus.acc_bin, bus.dump_valid, bus.busy,
         bus.done, bus.overrun, bus.frame_cnt} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got en=%b clr=%b bin=%0d dv=%b busy=%b done=%b ovr=%b cnt=%0d expected all 0",
               bus.acc_en, bus.acc_clear, bus.acc_bin, bus.dump_valid, bus.busy,
               bus.done, bus.overrun, bus.frame_cnt);
    end
    areset_n = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.acc_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release got busy=%b en=%b expected 0 0", bus.busy, bus.acc_en);
    end
  endtask

  task automatic test_nominal();
    bus.dump_ready = 1'b1;
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.frame_cnt !== 3'd0 || bus.acc_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nominal_armed got busy=%b cnt=%0d en=%b expected 1 0 0",
               bus.busy, bus.frame_cnt, bus.acc_en);
    end
    for (int f = 0; f < 4; f++) begin
      bus.fft_valid = 1'b1;
      tick();
      bus.fft_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (bus.acc_en !== 1'b1 || bus.acc_bin !== 2'(b) || bus.acc_clear !== (f == 0)) begin
          failures++;
          $display("[TB] FAIL nominal_bin f=%0d b=%0d got en=%b bin=%0d clr=%b expected 1 %0d %b",
                   f, b, bus.acc_en, bus.acc_bin, bus.acc_clear, b, (f == 0));
        end
        tick();
      end
      if (f < 3) begin
        checks++;
        if (bus.acc_en !== 1'b0 || bus.frame_cnt !== 3'(f + 1) || bus.dump_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL nominal_gap f=%0d got en=%b cnt=%0d dv=%b expected 0 %0d 0",
                   f, bus.acc_en, bus.frame_cnt, bus.dump_valid, f + 1);
        end
        if (f == 1) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (f == 1) begin
          checks++;
          if (bus.frame_cnt !== 3'd2 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_while_busy got cnt=%0d busy=%b expected 2 1",
                     bus.frame_cnt, bus.busy);
          end
        end
        tick();
        tick();
      end
    end
    checks++;
    if (bus.dump_valid !== 1'b1 || bus.acc_en !== 1'b0 || bus.frame_cnt !== 3'd4 || bus.done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nominal_dump got dv=%b en=%b cnt=%0d done=%b expected 1 0 4 0",
               bus.dump_valid, bus.acc_en, bus.frame_cnt, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.dump_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_cnt !== 3'd4) begin
      failures++;
      $display("[TB] FAIL nominal_done got done=%b dv=%b busy=%b cnt=%0d expected 1 0 0 4",
               bus.done, bus.dump_valid, bus.busy, bus.frame_cnt);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.frame_cnt !== 3'd4) begin
      failures++;
      $display("[TB] FAIL nominal_done_pulse got done=%b cnt=%0d expected 0 4", bus.done, bus.frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int ok_cycles;
    bus.dump_ready = 1'b1;
    pulse_start();
    bus.fft_valid = 1'b1;
    tick();
    ok_cycles = 0;
    for (int k = 0; k < 16; k++) begin
      bus.fft_valid = ((k % 4) == 3);
      checks++;
      if (bus.acc_en !== 1'b1 || bus.acc_bin !== 2'(k % 4) || bus.acc_clear !== (k < 4)) begin
        failures++;
        $display("[TB] FAIL b2b_bin k=%0d got en=%b bin=%0d clr=%b expected 1 %0d %b",
                 k, bus.acc_en, bus.acc_bin, bus.acc_clear, k % 4, (k < 4));
      end else begin
        ok_cycles++;
      end
      tick();
    end
    bus.fft_valid = 1'b0;
    checks++;
    if (bus.dump_valid !== 1'b1 || bus.acc_en !== 1'b0 || bus.overrun !== 1'b0 || bus.frame_cnt !== 3'd4) begin
      failures++;
      $display("[TB] FAIL b2b_end got dv=%b en=%b ovr=%b cnt=%0d (%0d good bins) expected 1 0 0 4",
               bus.dump_valid, bus.acc_en, bus.overrun, bus.frame_cnt, ok_cycles);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_done got done=%b busy=%b expected 1 0", bus.done, bus.busy);
    end
    tick();
  endtask

  task automatic test_overrun();
    bus.dump_ready = 1'b1;
    pulse_start();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (bus.acc_en !== 1'b1 || bus.acc_bin !== 2'(b)) begin
        failures++;
        $display("[TB] FAIL overrun_bin b=%0d got en=%b bin=%0d expected 1 %0d",
                 b, bus.acc_en, bus.acc_bin, b);
      end
      bus.fft_valid = (b == 1);
      tick();
      bus.fft_valid = 1'b0;
    end
    checks++;
    if (bus.acc_en !== 1'b0 || bus.overrun !== 1'b1 || bus.frame_cnt !== 3'd1) begin
      failures++;
      $display("[TB] FAIL overrun_flag got en=%b ovr=%b cnt=%0d expected 0 1 1",
               bus.acc_en, bus.overrun, bus.frame_cnt);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.overrun !== 1'b1 || bus.frame_cnt !== 3'd1) begin
      failures++;
      $display("[TB] FAIL overrun_hold got busy=%b ovr=%b cnt=%0d expected 0 1 1",
               bus.busy, bus.overrun, bus.frame_cnt);
    end
    pulse_start();
    checks++;
    if (bus.overrun !== 1'b0 || bus.frame_cnt !== 3'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_clear got ovr=%b cnt=%0d busy=%b expected 0 0 1",
               bus.overrun, bus.frame_cnt, bus.busy);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.dump_ready = 1'b0;
    pulse_start();
    bus.fft_valid = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      bus.fft_valid = ((k % 4) == 3);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      bus.fft_valid = k[0];
      checks++;
      if (bus.dump_valid !== 1'b1 || bus.acc_en !== 1'b0 || bus.done !== 1'b0 || bus.overrun !== 1'b0) begin
        failures++;
        $display("[TB] FAIL backpressure_hold k=%0d got dv=%b en=%b done=%b ovr=%b expected 1 0 0 0",
                 k, bus.dump_valid, bus.acc_en, bus.done, bus.overrun);
      end
      tick();
    end
    bus.fft_valid  = 1'b0;
    bus.dump_ready = 1'b1;
    checks++;
    if (bus.dump_valid !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL backpressure_pre got dv=%b done=%b expected 1 0", bus.dump_valid, bus.done);
    end
    tick();
    bus.dump_ready = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.dump_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL backpressure_done got done=%b dv=%b busy=%b expected 1 0 0",
               bus.done, bus.dump_valid, bus.busy);
    end
    tick();
  endtask

  task automatic test_abort();
    int done_seen;
    pulse_start();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    repeat (4) tick();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.acc_bin !== 2'd2 || bus.acc_en !== 1'b1 || bus.frame_cnt !== 3'd1) begin
      failures++;
      $display("[TB] FAIL abort_setup got bin=%0d en=%b cnt=%0d expected 2 1 1",
               bus.acc_bin, bus.acc_en, bus.frame_cnt);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.acc_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.frame_cnt !== 3'd1) begin
      failures++;
      $display("[TB] FAIL abort_idle got en=%b busy=%b done=%b cnt=%0d expected 0 0 0 1",
               bus.acc_en, bus.busy, bus.done, bus.frame_cnt);
    end
    done_seen = 0;
    bus.fft_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.done !== 1'b0 || bus.acc_en !== 1'b0) done_seen++;
    end
    bus.fft_valid = 1'b0;
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("[TB] FAIL abort_quiet got %0d active cycles expected 0", done_seen);
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.frame_cnt !== 3'd1) begin
      failures++;
      $display("[TB] FAIL start_abort got busy=%b cnt=%0d expected 0 1", bus.busy, bus.frame_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bus.dump_ready = 1'b1;
    pulse_start();
    bus.fft_valid = 1'b1;
    tick();
    bus.fft_valid = 1'b0;
    tick();
    #2;
    areset_n = 1'b0;
    #1;
    checks++;
    if ({bus.acc_en, bus.acc_clear, bus.acc_bin, bus.dump_valid, bus.busy,
         bus.done, bus.overrun, bus.frame_cnt} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got en=%b clr=%b bin=%0d dv=%b busy=%b done=%b ovr=%b cnt=%0d expected all 0",
               bus.acc_en, bus.acc_clear, bus.acc_bin, bus.dump_valid, bus.busy,
               bus.done, bus.overrun, bus.frame_cnt);
    end
    tick();
    areset_n = 1'b1;
    tick();
    pulse_start();
    bus.fft_valid = 1'b1;
    tick();
    checks++;
    if (bus.acc_en !== 1'b1 || bus.acc_bin !== 2'd0 || bus.acc_clear !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post_reset_first got en=%b bin=%0d clr=%b expected 1 0 1",
               bus.acc_en, bus.acc_bin, bus.acc_clear);
    end
    for (int k = 0; k < 16; k++) begin
      bus.fft_valid = ((k % 4) == 3);
      tick();
    end
    bus.fft_valid = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.frame_cnt !== 3'd4 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_run got done=%b cnt=%0d busy=%b expected 1 4 0",
               bus.done, bus.frame_cnt, bus.busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_overrun();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
